// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: EX-stage multiply/divide sequencer that owns HI/LO.
// Multiplies take MUL_LAT cycles in MUL; divides run a 32-step restoring
// divider. stall_o holds IF/ID/EX until the result reaches HI/LO.
// Ports: clk, rst (sync, active-high), op_valid_i, mult_i/multu_i/div_i/
//   divu_i/mthi_i/mtlo_i one-hot strobes, src_a_i (rs), src_b_i (rt),
//   flush_i, hi_o/lo_o (registered HI/LO), stall_o, busy_o (state!=IDLE).
// Optional: define HILO_MADD_MSUB_EN to add madd_i/maddu_i/msub_i/msubu_i,
//   which pass through MUL and then an ACC state that adds/subtracts the
//   product into {HI,LO}.
module hilo_muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid_i,
   input  logic        mult_i,
   input  logic        multu_i,
   input  logic        div_i,
   input  logic        divu_i,
   input  logic        mthi_i,
   input  logic        mtlo_i,
`ifdef HILO_MADD_MSUB_EN
   input  logic        madd_i,
   input  logic        maddu_i,
   input  logic        msub_i,
   input  logic        msubu_i,
`endif
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic        flush_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stall_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
`ifdef HILO_MADD_MSUB_EN
      S_ACC,
`endif
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sgn_q, sgn_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
`ifdef HILO_MADD_MSUB_EN
   logic        acc_q, acc_d;
   logic        sub_q, sub_d;
   logic [63:0] prod_q, prod_d;
   logic        is_acc;
`endif

   logic        is_mul;
   logic        is_div;
   logic        sgn_in;
   logic        wr_ok;
   logic        start;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] trial;
   logic [32:0] diff;
   logic        take;
   logic [31:0] rem_nx;
   logic [31:0] quo_nx;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;

`ifdef HILO_MADD_MSUB_EN
   assign is_acc = madd_i | maddu_i | msub_i | msubu_i;
   assign is_mul = mult_i | multu_i | is_acc;
   assign sgn_in = mult_i | div_i | madd_i | msub_i;
`else
   assign is_mul = mult_i | multu_i;
   assign sgn_in = mult_i | div_i;
`endif
   assign is_div = div_i | divu_i;

   assign wr_ok = op_valid_i & ~flush_i & (state_q == S_IDLE);
   assign start = wr_ok & (is_mul | is_div);

   assign mag_a = (sgn_in & src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
   assign mag_b = (sgn_in & src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

   // One restoring step: shift the next dividend bit into the remainder.
   // rem_q < dvs_q always holds, so a successful subtract fits 32 bits.
   assign trial  = {rem_q, quo_q[31]};
   assign diff   = trial - {1'b0, dvs_q};
   assign take   = (trial >= {1'b0, dvs_q});
   assign rem_nx = take ? diff[31:0] : trial[31:0];
   assign quo_nx = {quo_q[30:0], take};
   assign q_fix  = qneg_q ? (~quo_nx + 32'd1) : quo_nx;
   assign r_fix  = rneg_q ? (~rem_nx + 32'd1) : rem_nx;

   // Low 64 bits of the extended product equal the signed/unsigned product.
   assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
   assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = ext_a * ext_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef HILO_MADD_MSUB_EN
      acc_d   = acc_q;
      sub_d   = sub_q;
      prod_d  = prod_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d   = src_a_i;
               b_d   = src_b_i;
               sgn_d = sgn_in;
`ifdef HILO_MADD_MSUB_EN
               acc_d = is_acc;
               sub_d = msub_i | msubu_i;
`endif
               if (is_div) begin
                  state_d = S_DIV;
                  cnt_d   = 5'd0;
                  dvs_d   = mag_b;
                  quo_d   = mag_a;
                  rem_d   = 32'd0;
                  qneg_d  = sgn_in & (src_a_i[31] ^ src_b_i[31]);
                  rneg_d  = sgn_in & src_a_i[31];
               end else begin
                  state_d = S_MUL;
                  cnt_d   = 5'(MUL_LAT - 1);
               end
            end else if (wr_ok & mthi_i) begin
               hi_d = src_a_i;
            end else if (wr_ok & mtlo_i) begin
               lo_d = src_a_i;
            end
         end
         S_MUL: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               {hi_d, lo_d} = prod;
               state_d      = S_DONE;
`ifdef HILO_MADD_MSUB_EN
               if (acc_q) begin
                  {hi_d, lo_d} = {hi_q, lo_q};
                  prod_d       = prod;
                  state_d      = S_ACC;
               end
`endif
            end
         end
         S_DIV: begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_DONE;
               // Divide by zero: no fix-up, dividend passes to HI.
               if (b_q == 32'd0) begin
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = a_q;
               end else begin
                  lo_d = q_fix;
                  hi_d = r_fix;
               end
            end
         end
`ifdef HILO_MADD_MSUB_EN
         S_ACC: begin
            if (sub_q) begin
               {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
            end else begin
               {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
            end
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Flush wins over everything: drop in-flight work, keep HI/LO.
      if (flush_i) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         dvs_q   <= 32'd0;
         quo_q   <= 32'd0;
         rem_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
`ifdef HILO_MADD_MSUB_EN
         acc_q   <= 1'b0;
         sub_q   <= 1'b0;
         prod_q  <= 64'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef HILO_MADD_MSUB_EN
         acc_q   <= acc_d;
         sub_q   <= sub_d;
         prod_q  <= prod_d;
`endif
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (state_q != S_IDLE);
`ifdef HILO_MADD_MSUB_EN
   assign stall_o = ~flush_i & (start | (state_q == S_MUL) |
                                (state_q == S_DIV) | (state_q == S_ACC));
`else
   assign stall_o = ~flush_i & (start | (state_q == S_MUL) |
                                (state_q == S_DIV));
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: self-checking bench for hilo_muldiv_ctrl.
// Directed and $urandom stimulus checked against an arithmetic model.
module tb_hilo_muldiv_ctrl;

   localparam int unsigned MUL_LAT = 2;

   localparam int K_MULT  = 0;
   localparam int K_MULTU = 1;
   localparam int K_DIV   = 2;
   localparam int K_DIVU  = 3;
   localparam int K_MADD  = 6;
   localparam int K_MADDU = 7;
   localparam int K_MSUB  = 8;
   localparam int K_MSUBU = 9;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic        mult, multu, div, divu, mthi, mtlo;
`ifdef HILO_MADD_MSUB_EN
   logic        madd, maddu, msub, msubu;
`endif
   logic [31:0] src_a, src_b;
   logic        flush;
   logic [31:0] hi, lo;
   logic        stall, busy;

   int          errors;
   int          checks;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .op_valid_i (op_valid),
      .mult_i     (mult),
      .multu_i    (multu),
      .div_i      (div),
      .divu_i     (divu),
      .mthi_i     (mthi),
      .mtlo_i     (mtlo),
`ifdef HILO_MADD_MSUB_EN
      .madd_i     (madd),
      .maddu_i    (maddu),
      .msub_i     (msub),
      .msubu_i    (msubu),
`endif
      .src_a_i    (src_a),
      .src_b_i    (src_b),
      .flush_i    (flush),
      .hi_o       (hi),
      .lo_o       (lo),
      .stall_o    (stall),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {HI,LO} after the operation, from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_result(input int kind,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [63:0] acc);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (kind)
         K_MULT:  return 64'(sa * sb);
         K_MULTU: return {32'd0, a} * {32'd0, b};
         K_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         K_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         K_MADD, K_MSUB: begin
            p = 64'(sa * sb);
            return (kind == K_MADD) ? acc + p : acc - p;
         end
         default: begin
            p = {32'd0, a} * {32'd0, b};
            return (kind == K_MADDU) ? acc + p : acc - p;
         end
      endcase
   endfunction

   task automatic clear_inputs();
      op_valid = 0;
      mult = 0; multu = 0; div = 0; divu = 0; mthi = 0; mtlo = 0;
`ifdef HILO_MADD_MSUB_EN
      madd = 0; maddu = 0; msub = 0; msubu = 0;
`endif
      flush = 0;
   endtask

   task automatic set_strobe(input int kind);
      case (kind)
         K_MULT:  mult = 1;
         K_MULTU: multu = 1;
         K_DIV:   div = 1;
         K_DIVU:  divu = 1;
`ifdef HILO_MADD_MSUB_EN
         K_MADD:  madd = 1;
         K_MADDU: maddu = 1;
         K_MSUB:  msub = 1;
         K_MSUBU: msubu = 1;
`endif
         default: ;
      endcase
   endtask

   // Issue one mul/div op, hold op_valid through DONE, check latency/result.
   task automatic run_op(input int kind, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
      logic [63:0] exp;
      int lat;
      int cyc;
      @(negedge clk);
      op_valid = 1; set_strobe(kind);
      src_a = a; src_b = b;
      #1;
      exp = ref_result(kind, a, b, {exp_hi, exp_lo});
      if (kind <= K_MULTU) lat = MUL_LAT + 1;
      else if (kind <= K_DIVU) lat = 33;
      else lat = MUL_LAT + 2;
      cyc = 0;
      while (stall && cyc < 200) begin
         cyc++;
         @(negedge clk); #1;
      end
      checks++;
      if (cyc !== lat) begin
         errors++;
         $display("FAIL %s stall_cycles got %0d want %0d", nm, cyc, lat);
      end
      checks++;
      if (busy !== 1'b1 || hi !== exp[63:32] || lo !== exp[31:0]) begin
         errors++;
         $display("FAIL %s done got busy=%b hi=%h lo=%h want 1 %h %h",
                  nm, busy, hi, lo, exp[63:32], exp[31:0]);
      end
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || {hi, lo} !== exp) begin
         errors++;
         $display("FAIL %s after_done got busy=%b hi=%h lo=%h want 0 %h %h",
                  nm, busy, hi, lo, exp[63:32], exp[31:0]);
      end
      clear_inputs();
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
   endtask

   // Single mthi (which=0) or mtlo (which=1) in IDLE.
   task automatic run_mt(input int which, input logic [31:0] d);
      @(negedge clk);
      op_valid = 1; src_a = d;
      if (which == 0) mthi = 1; else mtlo = 1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL mt_stall got %b want 0", stall);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      if (which == 0) exp_hi = d; else exp_lo = d;
      checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
         errors++;
         $display("FAIL mt_write got %h %h want %h %h", hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      src_a = 0; src_b = 0;
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      exp_hi = 0; exp_lo = 0;
      checks++;
      if (hi !== 0 || lo !== 0 || stall !== 0 || busy !== 0) begin
         errors++;
         $display("FAIL reset got hi=%h lo=%h stall=%b busy=%b want 0 0 0 0",
                  hi, lo, stall, busy);
      end
   endtask

   task automatic test_mult();
      run_op(K_MULT,  32'hFFFF_FFFE, 32'd3, "mult");
      run_op(K_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
      checks++;
      if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL multu_const got %h %h want 00000002 fffffffa", hi, lo);
      end
   endtask

   task automatic test_div();
      run_op(K_DIV, 32'hFFFF_FFF9, 32'd2, "div");
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_const got hi=%h lo=%h want ffffffff fffffffd",
                  hi, lo);
      end
      run_op(K_DIVU, 32'hFFFF_FFF9, 32'd2, "divu");
      checks++;
      if (lo !== 32'h7FFF_FFFC || hi !== 32'h0000_0001) begin
         errors++;
         $display("FAIL divu_const got hi=%h lo=%h want 00000001 7ffffffc",
                  hi, lo);
      end
   endtask

   task automatic test_div_special();
      run_op(K_DIV, 32'h1234_5678, 32'd0, "div_by_zero");
      run_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
         errors++;
         $display("FAIL overflow_const got hi=%h lo=%h want 0 80000000",
                  hi, lo);
      end
      run_op(K_DIV, 32'h8000_0000, 32'd0, "div_by_zero_neg");
   endtask

   task automatic test_flush();
      run_mt(0, 32'hAAAA_0000);
      run_mt(1, 32'h0000_5555);
      @(negedge clk);
      op_valid = 1; div = 1;
      src_a = 32'd1000; src_b = 32'd7;
      repeat (11) @(negedge clk);
      flush = 1;
      #1;
      checks++;
      if (stall !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL flush_cycle got stall=%b busy=%b want 0 1", stall, busy);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (busy !== 0 || stall !== 0 || hi !== exp_hi || lo !== exp_lo) begin
         errors++;
         $display("FAIL flush_after got busy=%b stall=%b hi=%h lo=%h want 0 0 %h %h",
                  busy, stall, hi, lo, exp_hi, exp_lo);
      end
      // mthi together with flush must not write
      @(negedge clk);
      op_valid = 1; mthi = 1; flush = 1; src_a = 32'h1111_2222;
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (hi !== exp_hi) begin
         errors++;
         $display("FAIL mthi_flush got %h want %h", hi, exp_hi);
      end
   endtask

   task automatic test_reset_mid_mul();
      @(negedge clk);
      op_valid = 1; mult = 1;
      src_a = 32'd12345; src_b = 32'd678;
      @(negedge clk);
      rst = 1;
      clear_inputs();
      @(negedge clk);
      rst = 0;
      #1;
      exp_hi = 0; exp_lo = 0;
      checks++;
      if (hi !== 0 || lo !== 0 || busy !== 0 || stall !== 0) begin
         errors++;
         $display("FAIL reset_mid_mul got hi=%h lo=%h busy=%b stall=%b want 0",
                  hi, lo, busy, stall);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      op_valid = 1; mthi = 1; src_a = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall1 got %b want 0", stall);
      end
      @(negedge clk);
      mthi = 0; mtlo = 1; src_a = 32'h0BAD_F00D;
      #1;
      checks++;
      if (hi !== 32'hDEAD_BEEF || stall !== 1'b0) begin
         errors++;
         $display("FAIL b2b_mthi got hi=%h stall=%b want deadbeef 0", hi, stall);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      exp_hi = 32'hDEAD_BEEF; exp_lo = 32'h0BAD_F00D;
      checks++;
      if (lo !== 32'h0BAD_F00D || hi !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL b2b_mtlo got hi=%h lo=%h want deadbeef 0badf00d", hi, lo);
      end
   endtask

   task automatic test_random();
      int k;
      logic [31:0] a, b;
      for (int i = 0; i < 16; i++) begin
         k = int'($urandom_range(0, 5));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if (k <= K_DIVU) run_op(k, a, b, "random_op");
         else run_mt(k - 4, a);
      end
   endtask

`ifdef HILO_MADD_MSUB_EN
   task automatic test_madd();
      run_mt(0, 32'd0);
      run_mt(1, 32'hFFFF_FFFF);
      run_op(K_MADDU, 32'd1, 32'd1, "maddu");
      run_op(K_MSUB, 32'd2, 32'd3, "msub");
      checks++;
      if (hi !== 32'd0 || lo !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL msub_const got %h %h want 0 fffffffa", hi, lo);
      end
      run_op(K_MADD, $urandom, $urandom, "madd_rand");
      run_op(K_MSUBU, $urandom, $urandom, "msubu_rand");
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_mult();
      test_div();
      test_div_special();
      test_flush();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
`ifdef HILO_MADD_MSUB_EN
      test_madd();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
